mem_bus_sequencer: RTL and testbench

Sequences the processor's shared multiplexed address/data memory bus for two requesters: instruction fetch and data load/store. Arbitrates between them round-robin, then runs a fixed-phase bus cycle: address with ALE, address hold, access, capture, turnaround. All pad and memory-map strobes (MemEn, ALE, nME, nOE, nWE, ENB) are driven from this block, replacing ad-hoc strobe decoding in the core control FSM. Sits between the core control/datapath and the pad ring.

---
 rtl/mem_bus_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mem_bus_sequencer
//
// Owns the shared multiplexed address/data memory bus. Two requesters
// (instruction fetch, data load/store) are arbitrated round-robin. The winner
// then runs one fixed-phase bus cycle:
//   ADDR -> HOLD -> ACCESS (1 + WAIT_STATES cycles) -> CAPTURE -> TURN.
// Every pad and memory strobe is a flop output. Each flop's next value is
// decoded from the *next* state, so the strobes line up with the state they
// belong to.
//
// Handshake (both requesters):
//   Req is raised with its address/data and held until the matching Ack.
//   Ack is a one-cycle pulse in the TURN cycle. Address, wdata and DataWrite
//   are captured at the grant, so later changes have no effect on the cycle.
//   A Req dropped early still completes and still gets its Ack.
//
// Ports:
//   Clock, Reset             rising-edge clock, synchronous active-high reset
//   FetchReq/Addr/Ack/Data   instruction fetch requester (always a read)
//   DataReq/Write/Addr/Wdata data requester request side
//   DataAck/Rdata            data requester completion side
//   AdOut, AdIn              pad output value / pad input value
//   MemEn, ENB               pad output enable / pad input enable
//   ALE, nME, nOE, nWE       address latch, memory/output/write enables (n = low)
//   Busy                     high whenever the sequencer is not IDLE
//   DbgState                 current FSM state (state_t encoding)
//
// DW must equal AW: the address and the data share the same pads.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_bus_sequencer #(
    parameter int WAIT_STATES = 0,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          FetchReq,
    input  logic [AW-1:0] FetchAddr,
    output logic          FetchAck,
    output logic [DW-1:0] FetchData,
    input  logic          DataReq,
    input  logic          DataWrite,
    input  logic [AW-1:0] DataAddr,
    input  logic [DW-1:0] DataWdata,
    output logic          DataAck,
    output logic [DW-1:0] DataRdata,
    output logic [DW-1:0] AdOut,
    input  logic [DW-1:0] AdIn,
    output logic          MemEn,
    output logic          ENB,
    output logic          ALE,
    output logic          nME,
    output logic          nOE,
    output logic          nWE,
    output logic          Busy,
    output logic [2:0]    DbgState
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_TURN    = 3'd5
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    // Transaction state
    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;

    // Registered outputs
    logic          fetch_ack_q, fetch_ack_d;
    logic          data_ack_q, data_ack_d;
    logic [DW-1:0] fetch_data_q, fetch_data_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;
    logic [DW-1:0] ad_out_q, ad_out_d;
    logic          mem_en_q, mem_en_d;
    logic          enb_q, enb_d;
    logic          ale_q, ale_d;
    logic          n_me_q, n_me_d;
    logic          n_oe_q, n_oe_d;
    logic          n_we_q, n_we_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;

        // ---------------- next-state / transaction capture ----------------
        case (state_q)
            ST_IDLE: begin
                if (FetchReq || DataReq) begin
                    // Data wins if it is alone, or on a tie when fetch went last.
                    if (DataReq && (!FetchReq || last_q == OWN_FETCH)) begin
                        owner_d = OWN_DATA;
                        addr_d  = DataAddr;
                        wr_d    = DataWrite;
                        wdata_d = DataWdata;
                    end else begin
                        owner_d = OWN_FETCH;
                        addr_d  = FetchAddr;
                        wr_d    = 1'b0;
                    end
                    last_d  = owner_d;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_HOLD;
            ST_HOLD: begin
                cnt_d   = WAIT_CNT;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_TURN;
                // Read data is taken at the end of CAPTURE, into the owner's register.
                if (!wr_q) begin
                    if (owner_q == OWN_FETCH) begin
                        fetch_data_d = AdIn;
                    end else begin
                        data_rdata_d = AdIn;
                    end
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // ---------------- strobe decode for the state being entered ----------------
        fetch_ack_d = 1'b0;
        data_ack_d  = 1'b0;
        ad_out_d    = ad_out_q;
        mem_en_d    = 1'b0;
        enb_d       = 1'b0;
        ale_d       = 1'b0;
        n_me_d      = 1'b1;
        n_oe_d      = 1'b1;
        n_we_d      = 1'b1;
        busy_d      = (state_d != ST_IDLE);

        case (state_d)
            ST_ADDR: begin
                mem_en_d = 1'b1;
                ad_out_d = DW'(addr_d);
                ale_d    = 1'b1;
            end
            ST_HOLD: begin
                mem_en_d = 1'b1;
                ad_out_d = DW'(addr_d);
                n_me_d   = 1'b0;
            end
            ST_ACCESS: begin
                n_me_d = 1'b0;
                if (wr_d) begin
                    mem_en_d = 1'b1;
                    ad_out_d = wdata_d;
                    n_we_d   = 1'b0;
                end else begin
                    n_oe_d = 1'b0;
                    enb_d  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                n_me_d = 1'b0;
                if (wr_d) begin
                    // nWE already released; keep driving data as write hold time.
                    mem_en_d = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    n_oe_d = 1'b0;
                    enb_d  = 1'b1;
                end
            end
            ST_TURN: begin
                fetch_ack_d = (owner_d == OWN_FETCH);
                data_ack_d  = (owner_d == OWN_DATA);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            last_q       <= OWN_DATA;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
            ad_out_q     <= '0;
            mem_en_q     <= 1'b0;
            enb_q        <= 1'b0;
            ale_q        <= 1'b0;
            n_me_q       <= 1'b1;
            n_oe_q       <= 1'b1;
            n_we_q       <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
            ad_out_q     <= ad_out_d;
            mem_en_q     <= mem_en_d;
            enb_q        <= enb_d;
            ale_q        <= ale_d;
            n_me_q       <= n_me_d;
            n_oe_q       <= n_oe_d;
            n_we_q       <= n_we_d;
            busy_q       <= busy_d;
        end
    end

    assign FetchAck  = fetch_ack_q;
    assign DataAck   = data_ack_q;
    assign FetchData = fetch_data_q;
    assign DataRdata = data_rdata_q;
    assign AdOut     = ad_out_q;
    assign MemEn     = mem_en_q;
    assign ENB       = enb_q;
    assign ALE       = ale_q;
    assign nME       = n_me_q;
    assign nOE       = n_oe_q;
    assign nWE       = n_we_q;
    assign Busy      = busy_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
`timescale 1ns/1ps
module tb_mem_bus_sequencer;

    // Instance 0 runs with WAIT_STATES = 0, instance 1 with WAIT_STATES = 2.
    localparam logic [56:0] RESET_VEC = {2'b00, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b111, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req [2];
    logic [15:0] fetch_addr [2];
    logic        fetch_ack [2];
    logic [15:0] fetch_data [2];
    logic        data_req [2];
    logic        data_write [2];
    logic [15:0] data_addr [2];
    logic [15:0] data_wdata [2];
    logic        data_ack [2];
    logic [15:0] data_rdata [2];
    logic [15:0] ad_out [2];
    logic [15:0] ad_in [2];
    logic        mem_en [2];
    logic        enb [2];
    logic        ale [2];
    logic        n_me [2];
    logic        n_oe [2];
    logic        n_we [2];
    logic        busy [2];
    logic [2:0]  dbg_state [2];

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {dut, owner(1=data), expected FetchData, expected DataRdata}
    logic [33:0] exp_q[$];
    logic [15:0] model_fd [2];
    logic [15:0] model_rd [2];

    always #5 clk = ~clk;

    mem_bus_sequencer #(.WAIT_STATES(0), .AW(16), .DW(16)) u_dut0 (
        .Clock(clk), .Reset(rst),
        .FetchReq(fetch_req[0]), .FetchAddr(fetch_addr[0]), .FetchAck(fetch_ack[0]), .FetchData(fetch_data[0]),
        .DataReq(data_req[0]), .DataWrite(data_write[0]), .DataAddr(data_addr[0]), .DataWdata(data_wdata[0]),
        .DataAck(data_ack[0]), .DataRdata(data_rdata[0]),
        .AdOut(ad_out[0]), .AdIn(ad_in[0]), .MemEn(mem_en[0]), .ENB(enb[0]), .ALE(ale[0]),
        .nME(n_me[0]), .nOE(n_oe[0]), .nWE(n_we[0]), .Busy(busy[0]), .DbgState(dbg_state[0])
    );

    mem_bus_sequencer #(.WAIT_STATES(2), .AW(16), .DW(16)) u_dut1 (
        .Clock(clk), .Reset(rst),
        .FetchReq(fetch_req[1]), .FetchAddr(fetch_addr[1]), .FetchAck(fetch_ack[1]), .FetchData(fetch_data[1]),
        .DataReq(data_req[1]), .DataWrite(data_write[1]), .DataAddr(data_addr[1]), .DataWdata(data_wdata[1]),
        .DataAck(data_ack[1]), .DataRdata(data_rdata[1]),
        .AdOut(ad_out[1]), .AdIn(ad_in[1]), .MemEn(mem_en[1]), .ENB(enb[1]), .ALE(ale[1]),
        .nME(n_me[1]), .nOE(n_oe[1]), .nWE(n_we[1]), .Busy(busy[1]), .DbgState(dbg_state[1])
    );

    // ---------------- helpers (drivers / model, no checking) ----------------
    function automatic int ws(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [56:0] out_vec(input int d);
        return {fetch_ack[d], data_ack[d], fetch_data[d], data_rdata[d], ad_out[d],
                mem_en[d], ale[d], enb[d], n_me[d], n_oe[d], n_we[d], busy[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input int d);
        fetch_req[d]  = 1'b0;
        fetch_addr[d] = 16'h0000;
        data_req[d]   = 1'b0;
        data_write[d] = 1'b0;
        data_addr[d]  = 16'h0000;
        data_wdata[d] = 16'h0000;
        ad_in[d]      = 16'h0000;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model_fd[d] = 16'h0000;
            model_rd[d] = 16'h0000;
        end
    endtask

    task automatic push_exp(input int d, input bit owner, input bit wr, input logic [15:0] val);
        if (!wr) begin
            if (owner) model_rd[d] = val;
            else       model_fd[d] = val;
        end
        exp_q.push_back({d[0], owner, model_fd[d], model_rd[d]});
    endtask

    // ---------------- scoreboard / invariant monitor ----------------
    logic prev_fack [2];
    logic prev_dack [2];
    logic prev_ale  [2];

    always @(negedge clk) begin
        logic [33:0] e;
        logic [33:0] got;
        logic [5:0]  bad;
        for (int d = 0; d < 2; d++) begin
            bad[0] = mem_en[d] && enb[d];
            bad[1] = !n_oe[d] && !n_we[d];
            bad[2] = fetch_ack[d] && data_ack[d];
            bad[3] = (fetch_ack[d] && prev_fack[d]) || (data_ack[d] && prev_dack[d]);
            bad[4] = ale[d] && (dbg_state[d] != 3'd1);
            bad[5] = prev_ale[d] && (ale[d] || n_me[d]);
            checks++;
            if (bad != 6'd0) begin
                errors++;
                $display("FAIL invariant dut%0d t=%0t got violation bits %b required 000000", d, $time, bad);
            end
            if (fetch_ack[d] || data_ack[d]) begin
                checks++;
                got = {d[0], data_ack[d], fetch_data[d], data_rdata[d]};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected dut%0d t=%0t got ack %h required none", d, $time, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL ack_data dut%0d t=%0t got %h required %h", d, $time, got, e);
                    end
                end
            end
            prev_fack[d] = fetch_ack[d];
            prev_dack[d] = data_ack[d];
            prev_ale[d]  = ale[d];
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs(0);
        idle_inputs(1);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_vec(d) !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_values dut%0d got %h required %h", d, out_vec(d), RESET_VEC);
            end
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_fetch_read();
        int d = 0;
        int w = ws(0);
        fetch_addr[d] = 16'h0040;
        fetch_req[d]  = 1'b1;
        data_write[d] = 1'b1;  // must be ignored for fetch
        push_exp(d, 1'b0, 1'b0, 16'hBEEF);
        for (int c = 1; c <= 6 + w; c++) begin
            tick();
            ad_in[d] = (c == 4 + w) ? 16'hBEEF : 16'h0BAD;
            checks++;
            if (ale[d] !== (c == 1)) begin
                errors++;
                $display("FAIL fetch_ale cycle %0d got %b required %b", c, ale[d], (c == 1));
            end
            if (c <= 2) begin
                checks++;
                if (ad_out[d] !== 16'h0040 || mem_en[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL fetch_addr_phase cycle %0d got %h/%b required 0040/1", c, ad_out[d], mem_en[d]);
                end
            end
            checks++;
            if (n_oe[d] !== !(c >= 3 && c <= 4 + w)) begin
                errors++;
                $display("FAIL fetch_noe cycle %0d got %b required %b", c, n_oe[d], !(c >= 3 && c <= 4 + w));
            end
            checks++;
            if (fetch_ack[d] !== (c == 5 + w)) begin
                errors++;
                $display("FAIL fetch_ack_timing cycle %0d got %b required %b", c, fetch_ack[d], (c == 5 + w));
            end
            if (c == 5 + w) begin
                checks++;
                if (fetch_data[d] !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL fetch_data got %h required BEEF", fetch_data[d]);
                end
                fetch_req[d] = 1'b0;
            end
            if (c == 6 + w) begin
                checks++;
                if (busy[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_idle_busy got %b required 0", busy[d]);
                end
            end
        end
        data_write[d] = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        int d = 1;
        int w = ws(1);
        fetch_addr[d] = 16'h1357;
        fetch_req[d]  = 1'b1;
        push_exp(d, 1'b0, 1'b0, 16'hC0DE);
        for (int c = 1; c <= 6 + w; c++) begin
            tick();
            if (c == 2) fetch_addr[d] = 16'hFFFF;
            ad_in[d] = (c == 4 + w) ? 16'hC0DE : 16'h1111;
            if (c <= 2) begin
                checks++;
                if (ad_out[d] !== 16'h1357) begin
                    errors++;
                    $display("FAIL addr_change_hold cycle %0d got %h required 1357", c, ad_out[d]);
                end
            end
            if (c == 5 + w) fetch_req[d] = 1'b0;
        end
        tick();
    endtask

    task automatic test_store();
        int d = 1;
        int w = ws(1);
        data_addr[d]  = 16'h8000;
        data_wdata[d] = 16'h1234;
        data_write[d] = 1'b1;
        data_req[d]   = 1'b1;
        push_exp(d, 1'b1, 1'b1, 16'h0000);
        for (int c = 1; c <= 6 + w; c++) begin
            tick();
            ad_in[d] = 16'($urandom_range(0, 65535));
            if (c == 1) data_wdata[d] = 16'hFFFF;  // after grant: must not matter
            checks++;
            if (n_we[d] !== !(c >= 3 && c <= 3 + w)) begin
                errors++;
                $display("FAIL store_nwe cycle %0d got %b required %b", c, n_we[d], !(c >= 3 && c <= 3 + w));
            end
            checks++;
            if (mem_en[d] !== (c <= 4 + w)) begin
                errors++;
                $display("FAIL store_mem_en cycle %0d got %b required %b", c, mem_en[d], (c <= 4 + w));
            end
            if (c <= 4 + w) begin
                checks++;
                if (ad_out[d] !== ((c <= 2) ? 16'h8000 : 16'h1234)) begin
                    errors++;
                    $display("FAIL store_ad_out cycle %0d got %h required %h", c, ad_out[d], (c <= 2) ? 16'h8000 : 16'h1234);
                end
            end
            checks++;
            if (data_ack[d] !== (c == 5 + w)) begin
                errors++;
                $display("FAIL store_ack_timing cycle %0d got %b required %b", c, data_ack[d], (c == 5 + w));
            end
            if (c == 5 + w) begin
                checks++;
                if (data_rdata[d] !== model_rd[d]) begin
                    errors++;
                    $display("FAIL store_rdata_kept got %h required %h", data_rdata[d], model_rd[d]);
                end
                data_req[d] = 1'b0;
            end
        end
        data_write[d] = 1'b0;
        tick();
    endtask

    task automatic test_load_reset();
        int d = 1;
        int w = ws(1);
        // A normal load first, so the abandoned one has something to clear.
        data_addr[d]  = 16'h0100;
        data_write[d] = 1'b0;
        data_req[d]   = 1'b1;
        push_exp(d, 1'b1, 1'b0, 16'h5A5A);
        for (int c = 1; c <= 6 + w; c++) begin
            tick();
            ad_in[d] = (c == 4 + w) ? 16'h5A5A : 16'h2222;
            if (c == 5 + w) begin
                checks++;
                if (data_rdata[d] !== 16'h5A5A) begin
                    errors++;
                    $display("FAIL load_rdata got %h required 5A5A", data_rdata[d]);
                end
                data_req[d] = 1'b0;
            end
        end
        tick();
        // Second load, reset in the middle of ACCESS (cycle 4).
        data_addr[d] = 16'h0200;
        data_req[d]  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            ad_in[d] = 16'h6666;
            if (c == 4) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_vec(k) !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_mid_access dut%0d got %h required %h", k, out_vec(k), RESET_VEC);
            end
        end
        // Request is still held: it is re-issued from IDLE now.
        push_exp(d, 1'b1, 1'b0, 16'h7777);
        for (int c = 1; c <= 6 + w; c++) begin
            tick();
            ad_in[d] = (c == 4 + w) ? 16'h7777 : 16'h3333;
            checks++;
            if (data_ack[d] !== (c == 5 + w)) begin
                errors++;
                $display("FAIL reissue_ack_timing cycle %0d got %b required %b", c, data_ack[d], (c == 5 + w));
            end
            if (c == 5 + w) data_req[d] = 1'b0;
        end
        tick();
    endtask

    task automatic test_back_to_back_tie();
        int d = 0;
        int w = ws(0);
        int p = 6 + w;
        logic [15:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        fetch_addr[d] = 16'h1000;
        data_addr[d]  = 16'h2000;
        data_write[d] = 1'b0;
        fetch_req[d]  = 1'b1;
        data_req[d]   = 1'b1;
        // Last grant after reset is Data, so Fetch goes first.
        push_exp(d, 1'b0, 1'b0, vals[0]);
        push_exp(d, 1'b1, 1'b0, vals[1]);
        push_exp(d, 1'b0, 1'b0, vals[2]);
        push_exp(d, 1'b1, 1'b0, vals[3]);
        for (int c = 1; c <= 4 * p + 2; c++) begin
            tick();
            if ((c - 1) / p < 4) ad_in[d] = vals[(c - 1) / p];
            checks++;
            if (fetch_ack[d] !== (c == 5 + w || c == 2 * p + 5 + w)) begin
                errors++;
                $display("FAIL tie_fetch_ack cycle %0d got %b required %b", c, fetch_ack[d], (c == 5 + w || c == 2 * p + 5 + w));
            end
            checks++;
            if (data_ack[d] !== (c == p + 5 + w || c == 3 * p + 5 + w)) begin
                errors++;
                $display("FAIL tie_data_ack cycle %0d got %b required %b", c, data_ack[d], (c == p + 5 + w || c == 3 * p + 5 + w));
            end
            checks++;
            if (busy[d] !== ((c < 4 * p) && (c % p != 0))) begin
                errors++;
                $display("FAIL tie_busy cycle %0d got %b required %b", c, busy[d], ((c < 4 * p) && (c % p != 0)));
            end
            if (c == 2 * p + 5 + w) fetch_req[d] = 1'b0;
            if (c == 3 * p + 5 + w) data_req[d] = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int d = int'($urandom_range(0, 1));
            bit is_data = 1'($urandom_range(0, 1));
            bit wr = 1'($urandom_range(0, 1));
            logic [15:0] val = 16'($urandom_range(0, 65535));
            bit got_ack = 1'b0;
            ad_in[d]      = val;
            data_write[d] = wr;
            if (is_data) begin
                data_addr[d]  = 16'($urandom_range(0, 65535));
                data_wdata[d] = 16'($urandom_range(0, 65535));
                data_req[d]   = 1'b1;
                push_exp(d, 1'b1, wr, val);
            end else begin
                fetch_addr[d] = 16'($urandom_range(0, 65535));
                fetch_req[d]  = 1'b1;
                push_exp(d, 1'b0, 1'b0, val);
            end
            for (int c = 0; c < 40 && !got_ack; c++) begin
                tick();
                got_ack = fetch_ack[d] || data_ack[d];
            end
            checks++;
            if (!got_ack) begin
                errors++;
                $display("FAIL random_timeout txn %0d dut%0d got no ack required ack within 40 cycles", n, d);
            end
            fetch_req[d] = 1'b0;
            data_req[d]  = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_fack[d] = 1'b0;
            prev_dack[d] = 1'b0;
            prev_ale[d]  = 1'b0;
        end
        model_reset();
        test_reset();
        test_fetch_read();
        test_addr_change();
        test_store();
        test_load_reset();
        test_back_to_back_tie();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
